// File: rtl/maroc_sc_pkg.sv
// maroc_sc_pkg: shared definitions for the MAROC slow-control link.
// It holds the frame length, the bit position and width of each decoded
// configuration field, and the receiver state encoding. The transmitter,
// the receiver and the benches all import it.
package maroc_sc_pkg;

  localparam int FRAME_BITS  = 829;

  localparam int FLAGS_LSB   = 0;
  localparam int FLAGS_W     = 3;
  localparam int DAC2_LSB    = 3;
  localparam int DAC2_W      = 10;
  localparam int DAC1_LSB    = 13;
  localparam int DAC1_W      = 10;
  localparam int ADC_CFG_LSB = 23;
  localparam int ADC_CFG_W   = 4;
  localparam int MASK_OR_LSB = 27;
  localparam int MASK_OR_W   = 128;
  localparam int GLOBAL_LSB  = 155;
  localparam int GLOBAL_W    = 34;
  localparam int GAIN_LSB    = 189;
  localparam int GAIN_W      = 576;
  localparam int CTEST_LSB   = 765;
  localparam int CTEST_W     = 64;

  // Explicit codes keep the encoding stable for older tools and dumps.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2,
    OVER  = 2'd3
  } sc_state_t;

endpackage

// File: rtl/sc_edge_sync.sv
// sc_edge_sync: brings an asynchronous serial clock/data pair into the clk
// domain and produces a one-cycle strobe on each falling edge of the serial
// clock. Clock and data go through chains of equal depth, so d_out in the
// strobe cycle is the data bit that was present at the falling edge.
//
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   ck_in      : asynchronous serial clock
//   d_in       : asynchronous serial data, valid at the ck_in falling edge
//   fe         : one-cycle falling-edge strobe
//   d_out      : synchronized data aligned with fe
module sc_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ck_in,
  input  logic d_in,
  output logic fe,
  output logic d_out
);

  logic [SYNC_STAGES-1:0] ck_sync_p0;
  logic [SYNC_STAGES-1:0] d_sync_p0;
  logic                   ck_prev_p1;

  // The chains reset low: a clock that is already high at release reads as
  // a rising edge, never as a spurious falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ck_sync_p0 <= '0;
      d_sync_p0  <= '0;
      ck_prev_p1 <= 1'b0;
    end else begin
      ck_sync_p0 <= {ck_sync_p0[SYNC_STAGES-2:0], ck_in};
      d_sync_p0  <= {d_sync_p0[SYNC_STAGES-2:0], d_in};
      // ---- stage boundary: edge detect ----
      ck_prev_p1 <= ck_sync_p0[SYNC_STAGES-1];
    end
  end

  assign fe    = ck_prev_p1 & ~ck_sync_p0[SYNC_STAGES-1];
  assign d_out = d_sync_p0[SYNC_STAGES-1];

endmodule

// File: rtl/maroc_sc_receiver.sv
// maroc_sc_receiver: slave-side deserializer for the MAROC slow-control link.
// It oversamples CK_SC/D_SC on clk and shifts the frame in LSB first. When
// the frame is complete it latches it, decodes the configuration fields and
// flags short or over-length frames. Q_SC reproduces the daisy-chain
// shift-out, so a second frame pushes out the previous one bit by bit.
//
// Ports:
//   clk, rst_n   : system clock (>= 4x CK_SC), asynchronous active-low reset
//   CK_SC, D_SC  : serial clock and data from the transmitter
//   Q_SC         : bit shifted out of the LSB end of the shift register
//   frame        : last complete frame, bit 0 = first bit received
//   frame_valid  : one-cycle pulse when frame updates
//   busy         : a frame is in progress
//   err_short    : sticky, frame ended by timeout before all bits arrived
//   err_long     : sticky, extra edges arrived after a complete frame
//   err_clr      : synchronous clear of both sticky errors
//   flags3 .. ctest : decoded field slices of frame
module maroc_sc_receiver
  import maroc_sc_pkg::*;
#(
  parameter int FRAME_BITS   = maroc_sc_pkg::FRAME_BITS,
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  CK_SC,
  input  logic                  D_SC,
  output logic                  Q_SC,
  output logic [FRAME_BITS-1:0] frame,
  output logic                  frame_valid,
  output logic                  busy,
  output logic                  err_short,
  output logic                  err_long,
  input  logic                  err_clr,
  output logic [FLAGS_W-1:0]    flags3,
  output logic [DAC2_W-1:0]     dac2,
  output logic [DAC1_W-1:0]     dac1,
  output logic [ADC_CFG_W-1:0]  adc_cfg,
  output logic [MASK_OR_W-1:0]  mask_or,
  output logic [GLOBAL_W-1:0]   global_cfg,
  output logic [GAIN_W-1:0]     gain,
  output logic [CTEST_W-1:0]    ctest
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam int TMR_W = $clog2(IDLE_TIMEOUT + 1);

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_W'(FRAME_BITS)) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [TMR_W-1:0] tmr_inc(input logic [TMR_W-1:0] v);
    return (v == TMR_W'(IDLE_TIMEOUT)) ? v : v + TMR_W'(1);
  endfunction

  logic                  fe;
  logic                  d_sc_s;
  sc_state_t             state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [TMR_W-1:0]      idle_tmr;
  logic [FRAME_BITS-1:0] sreg;
  logic                  vld_p1;
  logic                  tmr_exp;
  logic                  last_bit;
  logic                  short_set;
  logic                  long_set;

  sc_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .ck_in (CK_SC),
    .d_in  (D_SC),
    .fe    (fe),
    .d_out (d_sc_s)
  );

  assign tmr_exp   = (idle_tmr == TMR_W'(IDLE_TIMEOUT));
  assign last_bit  = (bit_cnt == CNT_W'(FRAME_BITS - 1));
  // A timeout only counts as a short frame while still collecting bits.
  assign short_set = (state == SHIFT) && !fe && tmr_exp;
  assign long_set  = (state == DONE) && fe;

  // ---- stage boundary: shift / control on the edge strobe ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      idle_tmr    <= '0;
      sreg        <= '0;
      Q_SC        <= 1'b0;
      vld_p1      <= 1'b0;
      frame       <= '0;
      frame_valid <= 1'b0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;

      // The register shifts on every edge, in every state, so Q_SC always
      // mirrors a real MAROC chain even for over-length traffic.
      if (fe) begin
        Q_SC <= sreg[0];
        sreg <= {d_sc_s, sreg[FRAME_BITS-1:1]};
      end

      if (state == IDLE || fe) idle_tmr <= '0;
      else                     idle_tmr <= tmr_inc(idle_tmr);

      unique case (state)
        IDLE: begin
          if (fe) begin
            state   <= SHIFT;
            bit_cnt <= CNT_W'(1);
          end
        end
        SHIFT: begin
          if (fe) begin
            bit_cnt <= cnt_inc(bit_cnt);
            if (last_bit) begin
              state  <= DONE;
              vld_p1 <= 1'b1;
            end
          end else if (tmr_exp) begin
            state   <= IDLE;
            bit_cnt <= '0;
          end
        end
        DONE, OVER: begin
          if (fe) begin
            state   <= OVER;
            bit_cnt <= cnt_inc(bit_cnt);
          end else if (tmr_exp) begin
            state   <= IDLE;
            bit_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase

      // ---- stage boundary: frame latch, one cycle after the last shift ----
      frame_valid <= vld_p1;
      if (vld_p1) frame <= sreg;

      // A set in the same cycle as a clear wins.
      err_short <= short_set | (err_short & ~err_clr);
      err_long  <= long_set  | (err_long  & ~err_clr);
    end
  end

  assign busy       = (state != IDLE);

  assign flags3     = frame[FLAGS_LSB   +: FLAGS_W];
  assign dac2       = frame[DAC2_LSB    +: DAC2_W];
  assign dac1       = frame[DAC1_LSB    +: DAC1_W];
  assign adc_cfg    = frame[ADC_CFG_LSB +: ADC_CFG_W];
  assign mask_or    = frame[MASK_OR_LSB +: MASK_OR_W];
  assign global_cfg = frame[GLOBAL_LSB  +: GLOBAL_W];
  assign gain       = frame[GAIN_LSB    +: GAIN_W];
  assign ctest      = frame[CTEST_LSB   +: CTEST_W];

endmodule

// File: tb/tb_maroc_sc_receiver.sv
// tb_maroc_sc_receiver: directed bench for maroc_sc_receiver. It plays the
// transmitter role on CK_SC/D_SC (LSB first, data set while CK_SC is high,
// captured at the falling edge) and checks frames, fields, errors and the
// Q_SC chain output against vectors built here.
module tb_maroc_sc_receiver;

  localparam int FB = 829;

  logic           clk;
  logic           rst_n;
  logic           CK_SC;
  logic           D_SC;
  logic           err_clr;
  logic           Q_SC;
  logic [FB-1:0]  frame;
  logic           frame_valid;
  logic           busy;
  logic           err_short;
  logic           err_long;
  logic [2:0]     flags3;
  logic [9:0]     dac2;
  logic [9:0]     dac1;
  logic [3:0]     adc_cfg;
  logic [127:0]   mask_or;
  logic [33:0]    global_cfg;
  logic [575:0]   gain;
  logic [63:0]    ctest;

  int             ncmp;
  int             nfail;
  int             fv_cnt;
  int             q_idx;
  logic           q_pend;
  logic [FB-1:0]  q_seen;
  logic [831:0]   last_frame;
  int             half_ns;

  maroc_sc_receiver dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .CK_SC       (CK_SC),
    .D_SC        (D_SC),
    .Q_SC        (Q_SC),
    .frame       (frame),
    .frame_valid (frame_valid),
    .busy        (busy),
    .err_short   (err_short),
    .err_long    (err_long),
    .err_clr     (err_clr),
    .flags3      (flags3),
    .dac2        (dac2),
    .dac1        (dac1),
    .adc_cfg     (adc_cfg),
    .mask_or     (mask_or),
    .global_cfg  (global_cfg),
    .gain        (gain),
    .ctest       (ctest)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (!rst_n) fv_cnt <= 0;
    else if (frame_valid === 1'b1) fv_cnt <= fv_cnt + 1;
  end

  // Q_SC from the previous bit is recorded just before the next falling edge.
  task automatic record_q();
    if (q_pend) begin
      if (q_idx < FB) q_seen[q_idx] = Q_SC;
      q_idx++;
    end
    q_pend = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    D_SC = b;
    #(half_ns);
    record_q();
    q_pend = 1'b1;
    CK_SC = 1'b0;
    #(half_ns);
    CK_SC = 1'b1;
  endtask

  task automatic send_bits(input logic [831:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[i]);
  endtask

  task automatic gap();
    #(2 * half_ns);
    record_q();
    #1000;
  endtask

  task automatic test_reset();
    ncmp++; if (Q_SC !== 1'b0) begin nfail++; $display("FAIL reset_q_sc: got %0h want 0", Q_SC); end
    ncmp++; if (frame !== '0) begin nfail++; $display("FAIL reset_frame: got %0h want 0", frame); end
    ncmp++; if (frame_valid !== 1'b0) begin nfail++; $display("FAIL reset_frame_valid: got %0h want 0", frame_valid); end
    ncmp++; if (busy !== 1'b0) begin nfail++; $display("FAIL reset_busy: got %0h want 0", busy); end
    ncmp++; if (err_short !== 1'b0) begin nfail++; $display("FAIL reset_err_short: got %0h want 0", err_short); end
    ncmp++; if (err_long !== 1'b0) begin nfail++; $display("FAIL reset_err_long: got %0h want 0", err_long); end
    ncmp++; if (dac1 !== 10'h0) begin nfail++; $display("FAIL reset_dac1: got %0h want 0", dac1); end
  endtask

  task automatic test_full_frame();
    logic [831:0] f;
    int fv0;
    f = '0;
    f[22:13] = 10'h2A5;
    f[765] = 1'b1;
    fv0 = fv_cnt;
    q_idx = 0;
    send_bits(f, 100);
    ncmp++; if (busy !== 1'b1) begin nfail++; $display("FAIL full_busy: got %0h want 1", busy); end
    for (int i = 100; i < FB; i++) send_bit(f[i]);
    // Last falling edge was at -20 ns; frame_valid follows 4 clk cycles later.
    #10;
    ncmp++; if (frame_valid !== 1'b0) begin nfail++; $display("FAIL full_fv_early: got %0h want 0", frame_valid); end
    ncmp++; if (dac1 !== 10'h0) begin nfail++; $display("FAIL full_dac1_early: got %0h want 0", dac1); end
    #10;
    ncmp++; if (frame_valid !== 1'b1) begin nfail++; $display("FAIL full_fv_latency: got %0h want 1", frame_valid); end
    #10;
    ncmp++; if (frame_valid !== 1'b0) begin nfail++; $display("FAIL full_fv_width: got %0h want 0", frame_valid); end
    gap();
    ncmp++; if (fv_cnt - fv0 !== 1) begin nfail++; $display("FAIL full_fv_count: got %0d want 1", fv_cnt - fv0); end
    ncmp++; if (dac1 !== 10'h2A5) begin nfail++; $display("FAIL full_dac1: got %0h want 2a5", dac1); end
    ncmp++; if (ctest !== 64'h1) begin nfail++; $display("FAIL full_ctest: got %0h want 1", ctest); end
    ncmp++; if (frame[828:765] !== 64'h1) begin nfail++; $display("FAIL full_frame_top: got %0h want 1", frame[828:765]); end
    ncmp++; if (frame !== f[FB-1:0]) begin nfail++; $display("FAIL full_frame: got %0h want %0h", frame, f[FB-1:0]); end
    ncmp++; if ({flags3, dac2, adc_cfg} !== 17'h0) begin nfail++; $display("FAIL full_low_fields: got %0h want 0", {flags3, dac2, adc_cfg}); end
    ncmp++; if ((|mask_or) || (|global_cfg) || (|gain)) begin nfail++; $display("FAIL full_mid_fields: got %0h/%0h want 0", mask_or, global_cfg); end
    ncmp++; if ({err_short, err_long} !== 2'b00) begin nfail++; $display("FAIL full_errors: got %0b want 00", {err_short, err_long}); end
    ncmp++; if (busy !== 1'b0) begin nfail++; $display("FAIL full_busy_after: got %0h want 0", busy); end
    last_frame = f;
  endtask

  // Twenty random frames; each one also checks that Q_SC pushed out the
  // preceding frame bit by bit.
  task automatic test_random_loopback();
    logic [831:0] f;
    int fv0;
    fv0 = fv_cnt;
    for (int k = 0; k < 20; k++) begin
      f = '0;
      for (int i = 0; i < FB; i++) f[i] = 1'($urandom_range(0, 1));
      q_idx = 0;
      send_bits(f, FB);
      gap();
      ncmp++; if (frame !== f[FB-1:0]) begin nfail++; $display("FAIL random_frame_%0d: got %0h want %0h", k, frame, f[FB-1:0]); end
      ncmp++; if (q_seen !== last_frame[FB-1:0]) begin nfail++; $display("FAIL chain_q_sc_%0d: got %0h want %0h", k, q_seen, last_frame[FB-1:0]); end
      last_frame = f;
    end
    ncmp++; if (fv_cnt - fv0 !== 20) begin nfail++; $display("FAIL random_fv_count: got %0d want 20", fv_cnt - fv0); end
    ncmp++; if ({err_short, err_long} !== 2'b00) begin nfail++; $display("FAIL random_errors: got %0b want 00", {err_short, err_long}); end
  endtask

  task automatic test_short_frame();
    logic [831:0] s;
    int fv0;
    s = '0;
    for (int i = 0; i < 500; i++) s[i] = 1'(i % 2);
    fv0 = fv_cnt;
    send_bits(s, 500);
    gap();
    ncmp++; if (err_short !== 1'b1) begin nfail++; $display("FAIL short_err_short: got %0h want 1", err_short); end
    ncmp++; if (err_long !== 1'b0) begin nfail++; $display("FAIL short_err_long: got %0h want 0", err_long); end
    ncmp++; if (fv_cnt - fv0 !== 0) begin nfail++; $display("FAIL short_fv_count: got %0d want 0", fv_cnt - fv0); end
    ncmp++; if (frame !== last_frame[FB-1:0]) begin nfail++; $display("FAIL short_frame_kept: got %0h want %0h", frame, last_frame[FB-1:0]); end
    ncmp++; if (busy !== 1'b0) begin nfail++; $display("FAIL short_busy: got %0h want 0", busy); end
    err_clr = 1'b1;
    #10;
    err_clr = 1'b0;
    #10;
    ncmp++; if (err_short !== 1'b0) begin nfail++; $display("FAIL short_err_clr: got %0h want 0", err_short); end
  endtask

  task automatic test_long_frame();
    logic [831:0] g;
    int fv0;
    g = '0;
    for (int i = 0; i < 831; i++) g[i] = (i % 7 == 2) || (i >= FB);
    fv0 = fv_cnt;
    send_bits(g, FB);
    #40;
    ncmp++; if (fv_cnt - fv0 !== 1) begin nfail++; $display("FAIL long_fv_at_829: got %0d want 1", fv_cnt - fv0); end
    ncmp++; if (err_long !== 1'b0) begin nfail++; $display("FAIL long_err_early: got %0h want 0", err_long); end
    send_bit(g[829]);
    send_bit(g[830]);
    gap();
    ncmp++; if (err_long !== 1'b1) begin nfail++; $display("FAIL long_err_long: got %0h want 1", err_long); end
    ncmp++; if (err_short !== 1'b0) begin nfail++; $display("FAIL long_err_short: got %0h want 0", err_short); end
    ncmp++; if (fv_cnt - fv0 !== 1) begin nfail++; $display("FAIL long_fv_count: got %0d want 1", fv_cnt - fv0); end
    ncmp++; if (frame !== g[FB-1:0]) begin nfail++; $display("FAIL long_frame: got %0h want %0h", frame, g[FB-1:0]); end
    ncmp++; if (busy !== 1'b0) begin nfail++; $display("FAIL long_busy: got %0h want 0", busy); end
    err_clr = 1'b1;
    #10;
    err_clr = 1'b0;
    #10;
    ncmp++; if (err_long !== 1'b0) begin nfail++; $display("FAIL long_err_clr: got %0h want 0", err_long); end
    last_frame = g;
  endtask

  task automatic test_reset_mid_frame();
    logic [831:0] c;
    int fv0;
    c = '0;
    for (int i = 0; i < FB; i++) c[i] = (i % 5 == 1) || (i % 3 == 0);
    send_bits(c, 400);
    #20;
    rst_n = 1'b0;
    #10;
    ncmp++; if (busy !== 1'b0) begin nfail++; $display("FAIL rst_mid_busy: got %0h want 0", busy); end
    ncmp++; if (frame !== '0) begin nfail++; $display("FAIL rst_mid_frame: got %0h want 0", frame); end
    ncmp++; if (Q_SC !== 1'b0) begin nfail++; $display("FAIL rst_mid_q_sc: got %0h want 0", Q_SC); end
    #10;
    rst_n = 1'b1;
    #100;
    q_idx = 0;
    q_pend = 1'b0;
    fv0 = fv_cnt;
    send_bits(c, FB);
    gap();
    ncmp++; if (fv_cnt - fv0 !== 1) begin nfail++; $display("FAIL rst_mid_fv_count: got %0d want 1", fv_cnt - fv0); end
    ncmp++; if (frame !== c[FB-1:0]) begin nfail++; $display("FAIL rst_mid_frame_after: got %0h want %0h", frame, c[FB-1:0]); end
    ncmp++; if (q_seen !== '0) begin nfail++; $display("FAIL rst_mid_chain: got %0h want 0", q_seen); end
    ncmp++; if ({err_short, err_long} !== 2'b00) begin nfail++; $display("FAIL rst_mid_errors: got %0b want 00", {err_short, err_long}); end
  endtask

  initial begin
    ncmp       = 0;
    nfail      = 0;
    q_idx      = 0;
    q_pend     = 1'b0;
    q_seen     = '0;
    last_frame = '0;
    half_ns    = 20;
    rst_n      = 1'b0;
    CK_SC      = 1'b1;
    D_SC       = 1'b0;
    err_clr    = 1'b0;
    void'($urandom(32'd20240607));
    #100;
    rst_n = 1'b1;
    #10;
    test_reset();
    test_full_frame();
    test_random_loopback();
    test_short_frame();
    test_long_frame();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
